// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: instruction fetch sequencer.
// Owns the fetch PC, keeps one instruction-memory request outstanding at a
// time, hands each fetched word and its PC to decode, and drains any stale
// request when a branch, jump or trap redirects the PC.
module pc_fetch_ctrl #(
   parameter logic [31:0] RESET_VEC = 32'h0000_0000,
   parameter logic [31:0] TRAP_VEC  = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   input  logic        trap,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   input  logic        if_ready,
   output logic        misaligned,
   output logic [31:0] pc
);

   typedef enum logic [1:0] {
      IDLE,   // no request outstanding
      FETCH,  // request for pc outstanding
      HOLD,   // fetched word waiting for decode
      FLUSH   // stale request still outstanding after a redirect
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] flush_addr;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        fetch_done;

   // Trap wins over a branch/jump; both targets are forced word aligned.
   assign redirect    = trap | redirect_valid;
   assign redirect_pc = trap ? {TRAP_VEC[31:2], 2'b00} : {redirect_target[31:2], 2'b00};
   assign fetch_done  = (state == FETCH) && imem_ack;

   // A stale request keeps presenting the address it was issued with.
   assign imem_req  = (state == FETCH) || (state == FLUSH);
   assign imem_addr = (state == FLUSH) ? flush_addr : pc;
   assign if_valid  = (state == HOLD);

   // Next-state selection: redirect first, then handshake progress.
   always_comb begin
      // NOTE: default first so every path assigns state_nxt; no latch is inferred.
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (!redirect && !stall) state_nxt = FETCH;
         end
         FETCH: begin
            if (redirect)      state_nxt = imem_ack ? IDLE : FLUSH;
            else if (imem_ack) state_nxt = HOLD;
         end
         HOLD: begin
            if (redirect)      state_nxt = IDLE;
            else if (if_ready) state_nxt = stall ? IDLE : FETCH;
         end
         FLUSH: begin
            // The stale request must still complete; a redirect only moves pc.
            if (imem_ack) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Control state, fetch PC and the decode-side holding registers.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so all registers update from pre-edge values.
      if (reset) begin
         state      <= IDLE;
         pc         <= {RESET_VEC[31:2], 2'b00};
         misaligned <= 1'b0;
         if_pc      <= '0;
         if_instr   <= '0;
      end else begin
         state      <= state_nxt;
         misaligned <= !trap && redirect_valid && (redirect_target[1:0] != 2'b00);
         if (redirect)        pc <= redirect_pc;
         else if (fetch_done) pc <= pc + 32'd4;
         if (fetch_done && !redirect) begin
            if_pc    <= pc;
            if_instr <= imem_rdata;
         end
      end
   end

   // Capture the in-flight address when a redirect orphans a pending fetch.
   always_ff @(posedge clk) begin
      // NOTE: no reset needed; flush_addr is only observed in FLUSH, after it is loaded.
      if (state == FETCH && redirect && !imem_ack) flush_addr <= pc;
   end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: scenario bench for pc_fetch_ctrl with an instruction
// scoreboard. Each acknowledged fetch pushes its expected {pc, instr}; each
// decode handshake pops and compares.
module tb_pc_fetch_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        trap;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        if_ready;
   logic        misaligned;
   logic [31:0] pc;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   pc_fetch_ctrl #(
      .RESET_VEC(32'h0000_0000),
      .TRAP_VEC (32'h0000_0100)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_target(redirect_target),
      .trap           (trap),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_instr       (if_instr),
      .if_ready       (if_ready),
      .misaligned     (misaligned),
      .pc             (pc)
   );

   always #5 clk = ~clk;

   // Advance one clock; inputs set afterwards apply at the next edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Memory model: wait for a request, hold off 'delay' cycles, then ack once.
   task automatic serve_req(input int delay, input logic [31:0] data, input logic [31:0] exp_addr);
      int waited = 0;
      while (imem_req !== 1'b1 && waited < 20) begin
         step();
         waited++;
      end
      checks++;
      if (imem_req !== 1'b1) begin
         errors++;
         $display("FAIL req_timeout: imem_req=%b after %0d cycles, required 1 (addr %h)", imem_req, waited, exp_addr);
      end
      checks++;
      if (imem_addr !== exp_addr) begin
         errors++;
         $display("FAIL req_addr: imem_addr=%h required %h", imem_addr, exp_addr);
      end
      for (int i = 0; i < delay; i++) begin
         step();
         checks++;
         if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin
            errors++;
            $display("FAIL req_held: imem_req=%b imem_addr=%h required 1/%h", imem_req, imem_addr, exp_addr);
         end
      end
      imem_ack   = 1'b1;
      imem_rdata = data;
      sb.push_back('{pc: exp_addr, instr: data});
      step();
      imem_ack   = 1'b0;
      imem_rdata = '0;
   endtask

   // Decode model: wait for if_valid, compare against the scoreboard, accept.
   task automatic accept_instr();
      int   waited = 0;
      exp_t e;
      while (if_valid !== 1'b1 && waited < 20) begin
         step();
         waited++;
      end
      checks++;
      if (if_valid !== 1'b1) begin
         errors++;
         $display("FAIL valid_timeout: if_valid=%b after %0d cycles, required 1", if_valid, waited);
      end
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL sb_empty: got if_pc=%h if_instr=%h, required no instruction", if_pc, if_instr);
      end else begin
         e = sb.pop_front();
         checks++;
         if (if_pc !== e.pc || if_instr !== e.instr) begin
            errors++;
            $display("FAIL decode_data: if_pc=%h if_instr=%h required %h %h", if_pc, if_instr, e.pc, e.instr);
         end
      end
      if_ready = 1'b1;
      step();
      if_ready = 1'b0;
      checks++;
      if (if_valid !== 1'b0 || misaligned !== 1'b0) begin
         errors++;
         $display("FAIL valid_drop: if_valid=%b misaligned=%b required 0 0", if_valid, misaligned);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; stall = 1'b0; trap = 1'b0; redirect_valid = 1'b0;
      redirect_target = '0; imem_ack = 1'b0; imem_rdata = '0; if_ready = 1'b0;
      step();
      step();
      checks++;
      if (imem_req !== 1'b0 || if_valid !== 1'b0 || misaligned !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: req=%b valid=%b mis=%b required 0 0 0", imem_req, if_valid, misaligned);
      end
      checks++;
      if (pc !== 32'h0 || if_pc !== 32'h0 || if_instr !== 32'h0) begin
         errors++;
         $display("FAIL reset_data: pc=%h if_pc=%h if_instr=%h required 0 0 0", pc, if_pc, if_instr);
      end
      reset = 1'b0;
   endtask

   task automatic test_sequential();
      serve_req(1, 32'h0000_0013, 32'h0);
      accept_instr();
      serve_req(1, 32'h0000_0013, 32'h4);
      accept_instr();
      serve_req(1, 32'hABCD_0013, 32'h8);
      checks++;
      if (pc !== 32'hC) begin
         errors++;
         $display("FAIL seq_pc: pc=%h required 0000000c", pc);
      end
   endtask

   task automatic test_hold();
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_instr !== 32'hABCD_0013 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL hold_stable: valid=%b pc=%h instr=%h req=%b required 1 00000008 abcd0013 0",
                     if_valid, if_pc, if_instr, imem_req);
         end
      end
      accept_instr();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin
         errors++;
         $display("FAIL hold_next_req: req=%b addr=%h required 1 0000000c", imem_req, imem_addr);
      end
   endtask

   task automatic test_redirect_flush();
      redirect_valid = 1'b1; redirect_target = 32'h40;
      step();
      redirect_valid = 1'b0;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'hC || pc !== 32'h40 || if_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_enter: req=%b addr=%h pc=%h valid=%b required 1 0000000c 00000040 0",
                  imem_req, imem_addr, pc, if_valid);
      end
      for (int i = 0; i < 2; i++) begin
         step();
         checks++;
         if (imem_req !== 1'b1 || imem_addr !== 32'hC || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_hold: req=%b addr=%h valid=%b required 1 0000000c 0", imem_req, imem_addr, if_valid);
         end
      end
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      step();
      imem_ack = 1'b0; imem_rdata = '0;
      checks++;
      if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_drop: req=%b valid=%b required 0 0", imem_req, if_valid);
      end
      step();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h40 || if_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_refetch: req=%b addr=%h valid=%b required 1 00000040 0", imem_req, imem_addr, if_valid);
      end
      serve_req(0, 32'h0010_0093, 32'h40);
      accept_instr();
   endtask

   task automatic test_trap();
      serve_req(0, 32'h0000_1111, 32'h44);
      trap = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h80; if_ready = 1'b1;
      step();
      trap = 1'b0; redirect_valid = 1'b0; if_ready = 1'b0;
      sb.delete(sb.size() - 1);
      checks++;
      if (if_valid !== 1'b0 || pc !== 32'h100 || imem_req !== 1'b0 || misaligned !== 1'b0) begin
         errors++;
         $display("FAIL trap_take: valid=%b pc=%h req=%b mis=%b required 0 00000100 0 0",
                  if_valid, pc, imem_req, misaligned);
      end
      step();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
         errors++;
         $display("FAIL trap_fetch: req=%b addr=%h required 1 00000100", imem_req, imem_addr);
      end
      serve_req(1, 32'h0000_2222, 32'h100);
      accept_instr();
   endtask

   task automatic test_misaligned();
      redirect_valid = 1'b1; redirect_target = 32'h42;
      imem_ack = 1'b1; imem_rdata = 32'h0000_0BAD;
      step();
      redirect_valid = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
      checks++;
      if (misaligned !== 1'b1 || pc !== 32'h40 || imem_req !== 1'b0 || if_valid !== 1'b0) begin
         errors++;
         $display("FAIL mis_pulse: mis=%b pc=%h req=%b valid=%b required 1 00000040 0 0",
                  misaligned, pc, imem_req, if_valid);
      end
      step();
      checks++;
      if (misaligned !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
         errors++;
         $display("FAIL mis_after: mis=%b req=%b addr=%h required 0 1 00000040", misaligned, imem_req, imem_addr);
      end
      serve_req(0, 32'h0000_3333, 32'h40);
      accept_instr();
   endtask

   task automatic test_reset_mid();
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++;
      if (imem_req !== 1'b0 || if_valid !== 1'b0 || pc !== 32'h0) begin
         errors++;
         $display("FAIL rst_fetch: req=%b valid=%b pc=%h required 0 0 00000000", imem_req, if_valid, pc);
      end
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL stall_idle: req=%b required 0", imem_req);
         end
      end
      stall = 1'b0;
      serve_req(0, 32'h0000_4444, 32'h0);
      checks++;
      if (if_valid !== 1'b1) begin
         errors++;
         $display("FAIL rst_pre_valid: valid=%b required 1", if_valid);
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      sb.delete(sb.size() - 1);
      checks++;
      if (imem_req !== 1'b0 || if_valid !== 1'b0 || pc !== 32'h0) begin
         errors++;
         $display("FAIL rst_hold: req=%b valid=%b pc=%h required 0 0 00000000", imem_req, if_valid, pc);
      end
   endtask

   task automatic test_wrap();
      redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
      step();
      redirect_valid = 1'b0;
      checks++;
      if (pc !== 32'hFFFF_FFFC || misaligned !== 1'b0) begin
         errors++;
         $display("FAIL wrap_redirect: pc=%h mis=%b required fffffffc 0", pc, misaligned);
      end
      serve_req(0, 32'h0000_5555, 32'hFFFF_FFFC);
      checks++;
      if (pc !== 32'h0) begin
         errors++;
         $display("FAIL wrap_pc: pc=%h required 00000000", pc);
      end
      accept_instr();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         errors++;
         $display("FAIL wrap_fetch: req=%b addr=%h required 1 00000000", imem_req, imem_addr);
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_hold();
      test_redirect_flush();
      test_trap();
      test_misaligned();
      test_reset_mid();
      test_wrap();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover: %0d entries remain, required 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required scenario completion");
      $fatal(1, "watchdog expired");
   end

endmodule
